// File: rtl/pop_i2s_tx.sv
// Pull-side I2S transmitter: pops 24-bit samples from a pop/ack source once per slot and
// serializes them MSB first with the I2S one-bit delay. A missing ack becomes silence.
module pop_i2s_tx #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic        pop_o,
  input  logic        ack_i,
  input  logic [23:0] data_i,
  output logic        sck_o,
  output logic        lrck_o,
  output logic        sdata_o,
  output logic        underrun_o,
  output logic [15:0] underrun_cnt_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TmrW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StPop, StWait} fetch_e;

  fetch_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [23:0]       hold_q, hold_d;
  logic              sck_q, sck_d;
  logic              lrck_q, lrck_d;
  logic              sdata_q, sdata_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              fall;
  logic [5:0]        bit_nxt;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    tmr_d      = tmr_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    sck_d      = sck_q;
    lrck_d     = lrck_q;
    sdata_d    = sdata_q;
    underrun_d = 1'b0;
    cnt_d      = cnt_q;
    fall       = 1'b0;
    bit_nxt    = bit_cnt_q + 6'd1;

    if (div_q == DivW'(CLK_DIV - 1)) begin
      div_d = '0;
      sck_d = ~sck_q;
      fall  = sck_q;
    end else begin
      div_d = div_q + DivW'(1);
    end

    unique case (state_q)
      StIdle: ;
      StPop: begin
        state_d = StWait;
        tmr_d   = TmrW'(1);
      end
      StWait: begin
        if (ack_i) begin
          hold_d  = data_i;
          state_d = StIdle;
        end else if (tmr_q == TmrW'(ACK_TIMEOUT - 1)) begin
          hold_d     = '0;
          underrun_d = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          state_d    = StIdle;
        end else begin
          tmr_d = tmr_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Slot start loads the previously fetched sample and kicks off the next fetch.
    if (fall) begin
      bit_cnt_d = bit_nxt;
      lrck_d    = bit_nxt[5];
      if (bit_nxt[4:0] == 5'd0) begin
        shift_d = hold_q;
        sdata_d = 1'b0;
        state_d = StPop;
      end else if (bit_nxt[4:0] <= 5'd24) begin
        sdata_d = shift_q[23];
        shift_d = {shift_q[22:0], 1'b0};
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      state_q    <= StIdle;
      div_q      <= '0;
      tmr_q      <= '0;
      bit_cnt_q  <= 6'd63;
      shift_q    <= '0;
      hold_q     <= '0;
      sck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      tmr_q      <= tmr_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      sck_q      <= sck_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
    end
  end

  // The underrun count survives en_i going low; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign pop_o          = (state_q == StPop);
  assign sck_o          = sck_q;
  assign lrck_o         = lrck_q;
  assign sdata_o        = sdata_q;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_pop_i2s_tx.sv
// Bench for pop_i2s_tx: a randomized pop/ack source plus an I2S decoder feed slot-level
// expectations (one expected word per slot, fetched one slot earlier) checked per scenario.
module tb_pop_i2s_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        pop_o;
  logic        ack_i;
  logic [23:0] data_i;
  logic        sck_o;
  logic        lrck_o;
  logic        sdata_o;
  logic        underrun_o;
  logic [15:0] underrun_cnt_o;

  pop_i2s_tx #(
    .CLK_DIV    (4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en_i          (en_i),
    .pop_o         (pop_o),
    .ack_i         (ack_i),
    .data_i        (data_i),
    .sck_o         (sck_o),
    .lrck_o        (lrck_o),
    .sdata_o       (sdata_o),
    .underrun_o    (underrun_o),
    .underrun_cnt_o(underrun_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] w;
    bit          ch;
    bit          tail_ok;
    bit          lr_ok;
  } slot_t;

  int checks = 0;
  int passes = 0;

  slot_t       dec_q[$];
  logic [23:0] exp_q[$];
  int          slot_idx;
  int          exp_under;

  // Source configuration
  int          src_mode = 0;  // 0 constant, 1 ramp, 2 random
  logic [23:0] const_data = 24'hA5C3F0;
  logic [23:0] ramp = 24'd0;
  int          ack_delay = 1;
  bit          rand_delay = 0;
  bit          drop_all = 0;
  bit          drop_next = 0;
  bit          stray_en = 0;

  // Monitor state
  int cyc = 0;
  int first_pop = -1;
  int last_pop = -1;
  int pop_total = 0;
  int pop_consec = 0;
  int period_bad = 0;
  int under_seen = 0;
  int under_bad = 0;

  initial begin : monitor
    int          nrise;
    bit          prev_sck;
    bit          prev_pop;
    int          b;
    int          s;
    logic [23:0] acc;
    bit          tail_ok;
    bit          lr_ok;
    nrise = 0; prev_sck = 0; prev_pop = 0; acc = '0; tail_ok = 1; lr_ok = 1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst || !en_i) begin
        nrise = 0; prev_sck = 0; prev_pop = 0; first_pop = -1; last_pop = -1;
        continue;
      end
      if (pop_o) begin
        if (prev_pop) pop_consec++;
        if (first_pop < 0) first_pop = cyc;
        if (last_pop >= 0 && cyc - last_pop != 256) period_bad++;
        last_pop = cyc;
        pop_total++;
      end
      prev_pop = pop_o;
      if (underrun_o) begin
        under_seen++;
        if (cyc - last_pop != 16) under_bad++;
      end
      if (sck_o && !prev_sck) begin
        nrise++;
        // First rising edge after reset belongs to the idle bit before frame 0.
        if (nrise >= 2) begin
          b = (nrise - 2) % 64;
          s = b % 32;
          if (s == 0) begin
            acc = '0; tail_ok = (sdata_o == 1'b0); lr_ok = 1;
          end else if (s <= 24) begin
            acc = {acc[22:0], sdata_o};
          end else if (sdata_o != 1'b0) begin
            tail_ok = 0;
          end
          if (lrck_o != (b >= 32)) lr_ok = 0;
          if (s == 31) dec_q.push_back('{w: acc, ch: (b >= 32), tail_ok: tail_ok, lr_ok: lr_ok});
        end
      end
      prev_sck = sck_o;
    end
  end

  initial begin : source
    int          pop_cyc;
    int          dl;
    logic [23:0] d;
    bit          do_ack;
    pop_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      ack_i  = 1'b0;
      data_i = 24'($urandom);
      if (pop_o && !rst && en_i) begin
        pop_cyc = cyc;
        case (src_mode)
          0: d = const_data;
          1: begin d = ramp; ramp = ramp + 24'd1600; end
          default: d = 24'($urandom);
        endcase
        dl = rand_delay ? int'($urandom_range(1, 15)) : ack_delay;
        do_ack = !(drop_all || drop_next);
        drop_next = 0;
        if (!do_ack || dl >= 16) begin
          exp_q.push_back(24'd0);
          exp_under++;
        end else begin
          exp_q.push_back(d);
        end
        if (do_ack) begin
          repeat (dl) @(posedge clk);
          #1;
          ack_i  = 1'b1;
          data_i = d;
        end
      end else if (stray_en && cyc - pop_cyc >= 20 && $urandom_range(0, 15) == 0) begin
        ack_i = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic restart_model(input bit clear_under);
    exp_q.delete();
    exp_q.push_back(24'd0);
    dec_q.delete();
    slot_idx = 0;
    if (clear_under) exp_under = 0;
  endtask

  task automatic check_slots(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      int          waitc = 0;
      slot_t       got;
      logic [23:0] e;
      while (dec_q.size() == 0 && waitc < 700) begin
        @(negedge clk);
        waitc++;
      end
      checks++;
      if (dec_q.size() == 0) begin
        $display("FAIL %s slot %0d timeout: got no slot, required one within 700 clk",
                 name, slot_idx);
        continue;
      end
      passes++;
      got = dec_q.pop_front();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hxxxxxx;
      checks++;
      if (got.w !== e)
        $display("FAIL %s slot %0d word: got %h required %h", name, slot_idx, got.w, e);
      else passes++;
      checks++;
      if (got.ch !== slot_idx[0])
        $display("FAIL %s slot %0d channel: got %0d required %0d", name, slot_idx, got.ch,
                 slot_idx[0]);
      else passes++;
      checks++;
      if (!got.tail_ok)
        $display("FAIL %s slot %0d pad bits: got nonzero required zero", name, slot_idx);
      else passes++;
      checks++;
      if (!got.lr_ok)
        $display("FAIL %s slot %0d lrck: got wrong level required slot channel", name, slot_idx);
      else passes++;
      slot_idx++;
    end
  endtask

  task automatic check_first_pop(input int c0, input string name);
    int waitc = 0;
    while (first_pop < 0 && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (first_pop - c0 !== 7)
      $display("FAIL %s first pop: got clk %0d required clk 7", name, first_pop - c0);
    else passes++;
  endtask

  task automatic check_stream(input string name);
    checks++;
    if (underrun_cnt_o !== 16'(exp_under))
      $display("FAIL %s underrun_cnt: got %0d required %0d", name, underrun_cnt_o, exp_under);
    else passes++;
    checks++;
    if (pop_consec !== 0 || period_bad !== 0 || under_bad !== 0)
      $display("FAIL %s pop/underrun timing: got consec=%0d period_bad=%0d under_bad=%0d required 0",
               name, pop_consec, period_bad, under_bad);
    else passes++;
  endtask

  task automatic test_reset();
    int c0;
    drop_all = 1;
    @(negedge clk);
    rst = 1'b0;
    restart_model(1);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({sck_o, lrck_o, sdata_o, pop_o, underrun_o} !== 5'b0 || underrun_cnt_o !== 16'd0)
        $display("FAIL reset outputs: got sck=%b lrck=%b sdata=%b pop=%b ur=%b cnt=%0d required 0",
                 sck_o, lrck_o, sdata_o, pop_o, underrun_o, underrun_cnt_o);
      else passes++;
    end
    rst = 1'b0;
    drop_all = 0;
    restart_model(1);
    @(posedge clk);
    #2;
    c0 = cyc;
    check_first_pop(c0, "reset");
  endtask

  task automatic test_steady();
    src_mode = 0; ack_delay = 1;
    check_slots(6, "steady");
    check_stream("steady");
  endtask

  task automatic test_ramp();
    src_mode = 1; ramp = 24'd0; ack_delay = 2;
    check_slots(6, "ramp");
    check_stream("ramp");
  endtask

  task automatic test_no_ack();
    int seen0 = under_seen;
    drop_next = 1;
    check_slots(3, "no_ack");
    checks++;
    if (under_seen - seen0 !== 1)
      $display("FAIL no_ack pulses: got %0d required 1", under_seen - seen0);
    else passes++;
    check_stream("no_ack");
  endtask

  task automatic test_ack_limit();
    src_mode = 2;
    ack_delay = 15;
    check_slots(2, "ack15");
    ack_delay = 17;
    check_slots(2, "ack17");
    ack_delay = 1;
    check_slots(2, "ack_recover");
    check_stream("ack_limit");
  endtask

  task automatic test_enable();
    int pops0;
    int c0;
    bit bad = 0;
    repeat ($urandom_range(20, 200)) @(negedge clk);
    en_i = 1'b0;
    @(negedge clk);
    pops0 = pop_total;
    repeat (100) begin
      @(negedge clk);
      if ({sck_o, lrck_o, sdata_o, pop_o, underrun_o} !== 5'b0) bad = 1;
    end
    checks++;
    if (bad) $display("FAIL disable outputs: got activity required all 0");
    else passes++;
    checks++;
    if (pop_total !== pops0) $display("FAIL disable pops: got %0d required 0", pop_total - pops0);
    else passes++;
    checks++;
    if (underrun_cnt_o !== 16'(exp_under))
      $display("FAIL disable cnt kept: got %0d required %0d", underrun_cnt_o, exp_under);
    else passes++;
    en_i = 1'b1;
    restart_model(0);
    @(posedge clk);
    #2;
    c0 = cyc;
    check_first_pop(c0, "enable");
    check_slots(4, "enable");
    check_stream("enable");
  endtask

  task automatic test_random();
    src_mode = 2; rand_delay = 1; stray_en = 1;
    for (int i = 0; i < 10; i++) begin
      drop_next = ($urandom_range(0, 3) == 0);
      check_slots(1, "random");
    end
    check_stream("random");
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b1; ack_i = 1'b0; data_i = '0;
    exp_under = 0; slot_idx = 0;
    repeat (4) @(negedge clk);
    test_reset();
    test_steady();
    test_ramp();
    test_no_ack();
    test_ack_limit();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
